// File: rtl/div_pkg.sv
// Shared constants and types for the sequential restoring divider.
// The default width, the FSM state encoding and the divide-by-zero quotient.
package div_pkg;

  localparam int DIV_SIZE = 8;

  localparam logic [2*DIV_SIZE-1:0] QUOT_DBZ = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, then try to subtract.
// The compare is done at SIZE+1 bits so the shifted-out bit is never lost.
module div_step #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] r_i,
  input  logic            bit_i,
  input  logic [SIZE-1:0] divisor_i,
  output logic [SIZE-1:0] r_next_o,
  output logic            q_bit_o
);

  logic [SIZE:0] r_sh;
  logic [SIZE:0] dvs_ext;

  assign r_sh    = {r_i, bit_i};
  assign dvs_ext = {1'b0, divisor_i};
  assign q_bit_o = (r_sh >= dvs_ext);

  // The difference is always below the divisor, so it fits SIZE bits.
  assign r_next_o = q_bit_o ? SIZE'(r_sh - dvs_ext)
                            : r_sh[SIZE-1:0];

endmodule

// File: rtl/seq_div8.sv
// Sequential restoring divider: 2*SIZE-bit dividend by SIZE-bit divisor.
// One quotient bit per clock; done pulses once the results are stable.
module seq_div8
  import div_pkg::*;
#(
  parameter int SIZE = DIV_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2*SIZE-1:0] dividend,
  input  logic [SIZE-1:0]   divisor,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] quotient,
  output logic [SIZE-1:0]   remainder,
  output logic              div_by_zero
);

  localparam int CW = $clog2(2*SIZE);
  localparam logic [CW-1:0] LAST = CW'(2*SIZE-1);

  div_state_t state_q, state_d;

  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  logic [2*SIZE-1:0] sr_q, sr_d;
  logic [SIZE-1:0]   dvs_q, dvs_d;
  logic [SIZE-1:0]   r_q, r_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*SIZE-1:0] quot_q, quot_d;
  logic [SIZE-1:0]   rem_q, rem_d;
  logic              dbz_q, dbz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [SIZE-1:0] r_next;
  logic            q_bit;

  div_step #(
    .SIZE(SIZE)
  ) u_step (
    .r_i      (r_q),
    .bit_i    (sr_q[2*SIZE-1]),
    .divisor_i(dvs_q),
    .r_next_o (r_next),
    .q_bit_o  (q_bit)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = (state_q != IDLE);
    done_d  = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        // busy_q still high means done is showing this cycle.
        if (start && !busy_q) begin
          sr_d  = dividend;
          dvs_d = divisor;
          r_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        sr_d  = {sr_q[2*SIZE-2:0], q_bit};
        r_d   = r_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          quot_d  = {sr_q[2*SIZE-2:0], q_bit};
          rem_d   = r_next;
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div8.sv
// Scoreboard bench for seq_div8: directed divisions, latency, reset abort.
// Stimulus pushes expected results; a monitor pops them on each done.
module tb_seq_div8;
  import div_pkg::*;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int   total;
  int   bad;
  exp_t sb[$];

  seq_div8 #(
    .SIZE(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got q=%0d r=%0d want none",
                 quotient, remainder);
      end else begin
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.z));
      end
    end
  end

  task automatic run_op(input logic [15:0] a,
                        input logic [7:0]  b,
                        input logic [15:0] eq,
                        input logic [7:0]  er,
                        input logic        ez,
                        input int          inj,
                        input int          rk);
    int k;
    int bc;
    int lat;
    lat = (b == 8'd0) ? 1 : 2*DIV_SIZE+1;
    if (rk == 0) sb.push_back('{q: eq, r: er, z: ez});
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bc = 0;
    k  = 0;
    while (k < 40) begin
      @(posedge clk);
      #1 k++;
      if (inj != 0 && inj == k) begin
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 8'd3;
      end
      if (inj != 0 && inj + 1 == k) start = 1'b0;
      if (rk != 0 && rk == k) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_quot", 32'(quotient), 0);
        check("rst_rem", 32'(remainder), 0);
        break;
      end
      if (busy) bc++;
      if (done) break;
    end
    if (rk != 0) begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1 check("rst_idle_busy", 32'(busy), 0);
    end else begin
      check("latency", 32'(k), 32'(lat));
      check("busy_cycles", 32'(bc), 32'(lat));
      @(posedge clk);
      #1;
      check("done_pulse", 32'(done), 0);
      check("busy_drop", 32'(busy), 0);
    end
  endtask

  initial begin
    logic [7:0] vals [8];
    vals = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd100, 8'd128, 8'd200, 8'd254};
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_quot", 32'(quotient), 0);
    check("reset_rem", 32'(remainder), 0);
    check("reset_dbz", 32'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 0, 0);
    run_op(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 0, 0);
    run_op(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 0, 0);

    foreach (vals[i]) begin
      foreach (vals[j]) begin
        logic [15:0] p;
        p = 16'(vals[i]) * 16'(vals[j]);
        run_op(p, vals[j], 16'(vals[i]), 8'd0, 1'b0, 0, 0);
      end
    end

    run_op(16'd1234, 8'd0, QUOT_DBZ, 8'd0, 1'b1, 0, 0);
    run_op(16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 0, 0);
    run_op(16'd60000, 8'd250, 16'd240, 8'd0, 1'b0, 5, 0);
    run_op(16'd1000, 8'd7, 16'd0, 8'd0, 1'b0, 0, 8);
    run_op(16'd50, 8'd5, 16'd10, 8'd0, 1'b0, 0, 0);

    repeat (5) @(posedge clk);
    #1 check("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
